mem_dump_reader: RTL and testbench

Readback engine that streams a contiguous, word-aligned region of data memory out to an external host over a valid/ready interface. It is the counterpart of the external load path, which writes host data into data memory while the core is held in reset. This block reads memory back so the host can check results after a program run. It sits beside `data_mem` in the CPU top level. While it owns the memory port, the top level muxes its address onto `DataAdr` and forces the access width to a full word (funct3 = 3'b010).

---
 rtl/dump_pkg.sv | 26 ++
 rtl/mem_dump_reader.sv | 136 +++++++++++++
 tb/tb_mem_dump_reader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// Shared definitions for the data-memory readback engine and the CPU top-level port mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dump_pkg;

   // Readback FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } dump_state_e;

   // Bytes per memory word; the dump address advances by this amount per word
   localparam int WORD_BYTES = 4;

   // Load-word funct3. The top level forces this onto the memory access width
   // while the readback engine owns the data-memory port.
   localparam logic [2:0] FUNCT3_LW = 3'b010;

   // Clear the byte-offset bits so every access is a whole, aligned word
   function automatic logic [31:0] word_align(input logic [31:0] byte_adr);
      return {byte_adr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_dump_reader.sv
// Streams a contiguous, word-aligned region of data memory to a host over valid/ready.
// Latency: Start in cycle N -> Mem_Req in N+1 -> Dump_Valid in N+2; one word per 2 cycles.
// Backpressure: without Dump_Ready the offered word, its address and Mem_Adr hold; no re-read.
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   Dump_Start/Abort        one-cycle start request (IDLE only) / synchronous abort
//   Dump_Base, Dump_Count   start byte address (low 2 bits ignored), number of words
//   ReadData                combinational read data from data_mem
//   Mem_Req, Mem_Adr        memory-port ownership and word address (READ and SEND)
//   Dump_Valid/Ready/Data/Adr  output word handshake, data and its byte address
//   Dump_Busy, Dump_Done    not idle / one-cycle pulse after the last word is accepted
//   Dump_Sum                wrapping sum of every word captured in the current dump
module mem_dump_reader
   import dump_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Dump_Start,
   input  logic             Dump_Abort,
   input  logic [31:0]      Dump_Base,
   input  logic [CNT_W-1:0] Dump_Count,
   input  logic [31:0]      ReadData,
   output logic             Mem_Req,
   output logic [31:0]      Mem_Adr,
   output logic             Dump_Valid,
   input  logic             Dump_Ready,
   output logic [31:0]      Dump_Data,
   output logic [31:0]      Dump_Adr,
   output logic             Dump_Busy,
   output logic             Dump_Done,
   output logic [31:0]      Dump_Sum
);

   dump_state_e      state_q, state_d;
   logic [31:0]      addr_q,  addr_d;
   logic [CNT_W-1:0] rem_q,   rem_d;
   logic [31:0]      data_q,  data_d;
   logic [31:0]      sum_q,   sum_d;

   logic             handshake;
   logic             last_word;

   assign handshake = (state_q == ST_SEND) && Dump_Ready;
   assign last_word = (rem_q == CNT_W'(1));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      sum_d   = sum_q;

      case (state_q)
         ST_IDLE: begin
            // Abort has no meaning here, so a same-cycle Start is still honoured
            if (Dump_Start) begin
               sum_d = '0;
               if (Dump_Count != '0) begin
                  addr_d  = word_align(Dump_Base);
                  rem_d   = Dump_Count;
                  state_d = ST_READ;
               end else begin
                  // Empty dump: straight to the Done pulse, never touch memory
                  state_d = ST_DONE;
               end
            end
         end

         ST_READ: begin
            if (Dump_Abort) begin
               state_d = ST_IDLE;
            end else begin
               // Memory is combinational, so ReadData is valid for addr_q this cycle
               data_d  = ReadData;
               sum_d   = sum_q + ReadData;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            if (Dump_Abort) begin
               state_d = ST_IDLE;
            end else if (handshake) begin
               if (last_word) begin
                  state_d = ST_DONE;
               end else begin
                  rem_d   = rem_q - CNT_W'(1);
                  // Wraps naturally modulo 2^32
                  addr_d  = addr_q + 32'(WORD_BYTES);
                  state_d = ST_READ;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         sum_q   <= sum_d;
      end
   end

   // Outputs decode straight from registered state so reset clears them
   // immediately, without waiting for a clock edge.
   assign Mem_Req    = (state_q == ST_READ) || (state_q == ST_SEND);
   assign Mem_Adr    = addr_q;
   assign Dump_Valid = (state_q == ST_SEND);
   assign Dump_Data  = data_q;
   assign Dump_Adr   = addr_q;
   assign Dump_Busy  = (state_q != ST_IDLE);
   // An abort landing in the DONE cycle suppresses the pulse: aborted dumps never report Done
   assign Dump_Done  = (state_q == ST_DONE) && !Dump_Abort;
   assign Dump_Sum   = sum_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;

   localparam int CNT_W = 16;

   logic             clk;
   logic             reset;
   logic             Dump_Start;
   logic             Dump_Abort;
   logic [31:0]      Dump_Base;
   logic [CNT_W-1:0] Dump_Count;
   logic [31:0]      ReadData;
   logic             Mem_Req;
   logic [31:0]      Mem_Adr;
   logic             Dump_Valid;
   logic             Dump_Ready;
   logic [31:0]      Dump_Data;
   logic [31:0]      Dump_Adr;
   logic             Dump_Busy;
   logic             Dump_Done;
   logic [31:0]      Dump_Sum;

   int tests_run;
   int tests_failed;

   // Behavioural data memory: 256 words, indexed by byte address bits [9:2]
   logic [31:0] mem [256];
   assign ReadData = mem[Mem_Adr[9:2]];

   mem_dump_reader #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .Dump_Start (Dump_Start),
      .Dump_Abort (Dump_Abort),
      .Dump_Base  (Dump_Base),
      .Dump_Count (Dump_Count),
      .ReadData   (ReadData),
      .Mem_Req    (Mem_Req),
      .Mem_Adr    (Mem_Adr),
      .Dump_Valid (Dump_Valid),
      .Dump_Ready (Dump_Ready),
      .Dump_Data  (Dump_Data),
      .Dump_Adr   (Dump_Adr),
      .Dump_Busy  (Dump_Busy),
      .Dump_Done  (Dump_Done),
      .Dump_Sum   (Dump_Sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_req"}, 32'(Mem_Req),    32'd0);
      chk({tag, "_valid"},   32'(Dump_Valid), 32'd0);
      chk({tag, "_busy"},    32'(Dump_Busy),  32'd0);
      chk({tag, "_done"},    32'(Dump_Done),  32'd0);
      chk({tag, "_mem_adr"}, Mem_Adr,   32'd0);
      chk({tag, "_data"},    Dump_Data, 32'd0);
      chk({tag, "_adr"},     Dump_Adr,  32'd0);
      chk({tag, "_sum"},     Dump_Sum,  32'd0);
   endtask

   // mode: 0 = Ready always high, 1 = random Ready, 2 = Ready low 5 cycles on word 1
   // abort_word: index of the word whose SEND gets aborted, -1 for none
   task automatic run_dump(input logic [31:0] base, input int count, input int mode,
                           input int abort_word, input bit abort_with_start);
      logic [31:0] exp_adr [$];
      logic [31:0] exp_dat [$];
      logic [31:0] exp_sum;
      logic [31:0] part_sum;
      logic [31:0] a;
      logic [31:0] held_d;
      logic [31:0] held_a;
      int          idx, k, reads, stall;
      bit          done_seen, aborted, holding;

      // Reference: word list, full sum and sum captured up to the aborted word
      a        = {base[31:2], 2'b00};
      exp_sum  = '0;
      part_sum = '0;
      for (int i = 0; i < count; i++) begin
         exp_adr.push_back(a);
         exp_dat.push_back(mem[a[9:2]]);
         exp_sum = exp_sum + mem[a[9:2]];
         if (i <= abort_word) part_sum = part_sum + mem[a[9:2]];
         a = a + 32'd4;
      end

      @(negedge clk);
      Dump_Base  = base;
      Dump_Count = count[CNT_W-1:0];
      Dump_Start = 1'b1;
      Dump_Abort = abort_with_start;
      Dump_Ready = 1'b0;
      @(negedge clk);
      Dump_Start = 1'b0;
      Dump_Abort = 1'b0;

      idx = 0; k = 1; reads = 0; stall = 0;
      done_seen = 0; aborted = 0; holding = 0;
      held_d = '0; held_a = '0;

      while (!done_seen && !aborted && k < 200) begin
         if (k == 1 && count != 0) chk("req_at_n1", 32'(Mem_Req), 32'd1);
         if (Mem_Req && !Dump_Valid) begin
            reads++;
            if (idx < count) chk("mem_adr_read", Mem_Adr, exp_adr[idx]);
         end
         if (Dump_Valid) begin
            if (idx < count) begin
               chk("dump_data", Dump_Data, exp_dat[idx]);
               chk("dump_adr",  Dump_Adr,  exp_adr[idx]);
               chk("mem_adr_send", Mem_Adr, exp_adr[idx]);
               chk("req_in_send", 32'(Mem_Req), 32'd1);
            end else begin
               chk("extra_valid", 32'(Dump_Valid), 32'd0);
            end
            if (holding) begin
               chk("hold_data", Dump_Data, held_d);
               chk("hold_adr",  Dump_Adr,  held_a);
            end
         end else if (holding) begin
            chk("valid_dropped", 32'(Dump_Valid), 32'd1);
         end
         if (Dump_Done) begin
            done_seen = 1;
            chk("done_words", 32'(idx), 32'(count));
            if (mode == 0) chk("done_cycle", 32'(k), 32'(2 * count + 1));
            chk("sum", Dump_Sum, exp_sum);
            chk("reads", 32'(reads), 32'(count));
            chk("busy_in_done", 32'(Dump_Busy), 32'd1);
         end

         // Drive for the coming edge
         Dump_Ready = 1'b0;
         if (Dump_Valid && idx == abort_word) begin
            Dump_Abort = 1'b1;
            aborted    = 1;
         end else begin
            case (mode)
               0: Dump_Ready = 1'b1;
               1: Dump_Ready = 1'($urandom_range(0, 1));
               default: begin
                  if (idx == 1 && stall < 5) stall++;
                  else Dump_Ready = 1'b1;
               end
            endcase
         end
         holding = Dump_Valid && !Dump_Ready && !aborted;
         held_d  = Dump_Data;
         held_a  = Dump_Adr;
         if (Dump_Valid && Dump_Ready) idx++;

         @(negedge clk);
         k++;
      end
      Dump_Ready = 1'b0;
      Dump_Abort = 1'b0;

      if (aborted) begin
         chk("abort_busy",  32'(Dump_Busy),  32'd0);
         chk("abort_valid", 32'(Dump_Valid), 32'd0);
         chk("abort_req",   32'(Mem_Req),    32'd0);
         chk("abort_sum",   Dump_Sum, part_sum);
         for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 32'(Dump_Done), 32'd0);
            @(negedge clk);
         end
      end else if (!done_seen) begin
         chk("timeout", 32'(done_seen), 32'd1);
      end else begin
         chk("idle_after_done", 32'(Dump_Busy), 32'd0);
         chk("sum_holds", Dump_Sum, exp_sum);
      end
   endtask

   task automatic reset_mid_read();
      int guard;
      @(negedge clk);
      Dump_Base  = 32'h0;
      Dump_Count = 16'd3;
      Dump_Start = 1'b1;
      Dump_Ready = 1'b1;
      @(negedge clk);
      Dump_Start = 1'b0;
      // Wait for the second READ (after the first handshake)
      guard = 0;
      while (!(Mem_Req && !Dump_Valid && Mem_Adr == 32'h4) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("reach_second_read", 32'(guard < 50), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      @(negedge clk);
      reset      = 1'b0;
      Dump_Ready = 1'b0;
      chk_reset_outputs("after_midreset");
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset      = 1'b1;
      Dump_Start = 1'b0;
      Dump_Abort = 1'b0;
      Dump_Base  = '0;
      Dump_Count = '0;
      Dump_Ready = 1'b0;

      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h11111111;
      mem[1] = 32'h22222222;
      mem[2] = 32'h33333333;

      #1;
      chk_reset_outputs("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Directed cases
      run_dump(32'h0000_0000, 3, 0, -1, 0);   // basic 3-word dump, Done at N+7
      run_dump(32'h0000_0000, 3, 2, -1, 0);   // Ready low 5 cycles on second word
      run_dump(32'h0000_0006, 1, 0, -1, 0);   // unaligned base
      run_dump(32'hFFFF_FFFC, 2, 0, -1, 0);   // address wrap
      run_dump(32'h0000_0010, 0, 0, -1, 0);   // empty dump
      run_dump(32'h0000_0000, 3, 0,  1, 0);   // abort during second SEND
      run_dump(32'h0000_0020, 1, 0, -1, 1);   // abort in IDLE with Start still taken
      reset_mid_read();
      run_dump(32'h0000_0000, 3, 0, -1, 0);   // normal completion after reset

      // Randomized dumps
      for (int t = 0; t < 12; t++) begin
         run_dump($urandom, $urandom_range(1, 8), $urandom_range(0, 1), -1, 0);
      end
      for (int t = 0; t < 3; t++) begin
         run_dump($urandom, 4, 1, $urandom_range(0, 3), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
